// File: rtl/ball_motion_ctrl.sv
//------------------------------------------------------------------------------
// ball_motion_ctrl : brick-breaker ball engine (erase / step / redraw per tick)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ball_motion_ctrl #(
  parameter int SCREEN_W     = 160,
  parameter int SCREEN_H     = 120,
  parameter int X_W          = 8,
  parameter int Y_W          = 7,
  parameter int BALL_START_X = 80,
  parameter int BALL_START_Y = 60,
  parameter int PADDLE_Y     = 110,
  parameter int PADDLE_W     = 16
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           tick,
  input  logic           go,
  input  logic [X_W-1:0] paddle_x,
  input  logic           plot_done,
  output logic           plot_req,
  output logic [X_W-1:0] plot_x,
  output logic [Y_W-1:0] plot_y,
  output logic           plot_colour,
  output logic [X_W-1:0] ball_x,
  output logic [Y_W-1:0] ball_y,
  output logic           dir_x,
  output logic           dir_y,
  output logic           miss,
  output logic           tick_overrun
);

  localparam logic [2:0] c_IDLE      = 3'd0;
  localparam logic [2:0] c_WAIT_TICK = 3'd1;
  localparam logic [2:0] c_ERASE     = 3'd2;
  localparam logic [2:0] c_MOVE      = 3'd3;
  localparam logic [2:0] c_DRAW      = 3'd4;

  localparam logic [X_W-1:0] c_X_MAX   = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] c_Y_MAX   = Y_W'(SCREEN_H - 1);
  localparam logic [Y_W-1:0] c_Y_PAD   = Y_W'(PADDLE_Y - 1);
  localparam logic [X_W-1:0] c_X_START = X_W'(BALL_START_X);
  localparam logic [Y_W-1:0] c_Y_START = Y_W'(BALL_START_Y);
  localparam logic [X_W-1:0] c_X_ONE   = X_W'(1);
  localparam logic [Y_W-1:0] c_Y_ONE   = Y_W'(1);
  localparam logic [X_W:0]   c_PAD_SPAN = (X_W+1)'(PADDLE_W - 1);

  logic [2:0]     r_state;
  logic [X_W:0]   w_pad_right;
  logic           w_hit;
  logic [X_W-1:0] w_next_x;
  logic [Y_W-1:0] w_next_y;
  logic           w_next_dir_x;
  logic           w_next_dir_y;
  logic           w_miss;

  // Paddle right edge is widened by one bit so a paddle near x=255 cannot wrap.
  assign w_pad_right = {1'b0, paddle_x} + c_PAD_SPAN;
  assign w_hit       = (ball_x >= paddle_x) && ({1'b0, ball_x} <= w_pad_right);

  always_comb begin
    w_next_x     = ball_x;
    w_next_y     = ball_y;
    w_next_dir_x = dir_x;
    w_next_dir_y = dir_y;
    w_miss       = 1'b0;

    if (dir_x) begin
      if (ball_x == c_X_MAX) begin
        w_next_dir_x = 1'b0;
        w_next_x     = ball_x - c_X_ONE;
      end else begin
        w_next_x     = ball_x + c_X_ONE;
      end
    end else if (ball_x == '0) begin
      w_next_dir_x = 1'b1;
      w_next_x     = ball_x + c_X_ONE;
    end else begin
      w_next_x     = ball_x - c_X_ONE;
    end

    if (!dir_y) begin
      if (ball_y == '0) begin
        w_next_dir_y = 1'b1;
        w_next_y     = ball_y + c_Y_ONE;
      end else begin
        w_next_y     = ball_y - c_Y_ONE;
      end
    end else if (ball_y == c_Y_PAD && w_hit) begin
      w_next_dir_y = 1'b0;
      w_next_y     = ball_y - c_Y_ONE;
    end else if (ball_y == c_Y_MAX) begin
      w_miss       = 1'b1;
    end else begin
      w_next_y     = ball_y + c_Y_ONE;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= c_IDLE;
      ball_x       <= c_X_START;
      ball_y       <= c_Y_START;
      dir_x        <= 1'b1;
      dir_y        <= 1'b0;
      plot_req     <= 1'b0;
      plot_x       <= '0;
      plot_y       <= '0;
      plot_colour  <= 1'b0;
      miss         <= 1'b0;
      tick_overrun <= 1'b0;
    end else begin
      miss <= 1'b0;
      if (tick && (r_state != c_WAIT_TICK)) begin
        tick_overrun <= 1'b1;
      end

      case (r_state)
        c_IDLE: begin
          if (go) begin
            r_state     <= c_DRAW;
            plot_req    <= 1'b1;
            plot_x      <= ball_x;
            plot_y      <= ball_y;
            plot_colour <= 1'b1;
          end
        end
        c_WAIT_TICK: begin
          if (tick) begin
            r_state     <= c_ERASE;
            plot_req    <= 1'b1;
            plot_x      <= ball_x;
            plot_y      <= ball_y;
            plot_colour <= 1'b0;
          end
        end
        c_ERASE: begin
          if (plot_req && plot_done) begin
            plot_req <= 1'b0;
            r_state  <= c_MOVE;
          end
        end
        c_MOVE: begin
          if (w_miss) begin
            miss    <= 1'b1;
            ball_x  <= c_X_START;
            ball_y  <= c_Y_START;
            dir_x   <= 1'b1;
            dir_y   <= 1'b0;
            r_state <= c_IDLE;
          end else begin
            ball_x      <= w_next_x;
            ball_y      <= w_next_y;
            dir_x       <= w_next_dir_x;
            dir_y       <= w_next_dir_y;
            r_state     <= c_DRAW;
            plot_req    <= 1'b1;
            plot_x      <= w_next_x;
            plot_y      <= w_next_y;
            plot_colour <= 1'b1;
          end
        end
        c_DRAW: begin
          if (plot_req && plot_done) begin
            plot_req <= 1'b0;
            r_state  <= c_WAIT_TICK;
          end
        end
        default: begin
          r_state  <= c_IDLE;
          plot_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ball_motion_ctrl.sv
// Bench for ball_motion_ctrl: random paddle placement against a reflect-then-move ball model.
`default_nettype none

module tb_ball_motion_ctrl;

  logic       clock = 1'b0;
  logic       resetn;
  logic       tick;
  logic       go;
  logic [7:0] paddle_x;
  logic       plot_done;
  logic       plot_req;
  logic [7:0] plot_x;
  logic [6:0] plot_y;
  logic       plot_colour;
  logic [7:0] ball_x;
  logic [6:0] ball_y;
  logic       dir_x;
  logic       dir_y;
  logic       miss;
  logic       tick_overrun;

  int tests = 0;
  int fails = 0;

  // Ball model: position plus a direction flag per axis (1 = right / down).
  int mx, my, mdx, mdy;

  ball_motion_ctrl dut (
    .clock        (clock),
    .resetn       (resetn),
    .tick         (tick),
    .go           (go),
    .paddle_x     (paddle_x),
    .plot_done    (plot_done),
    .plot_req     (plot_req),
    .plot_x       (plot_x),
    .plot_y       (plot_y),
    .plot_colour  (plot_colour),
    .ball_x       (ball_x),
    .ball_y       (ball_y),
    .dir_x        (dir_x),
    .dir_y        (dir_y),
    .miss         (miss),
    .tick_overrun (tick_overrun)
  );

  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mx = 80; my = 60; mdx = 1; mdy = 0;
  endtask

  // Reflect at a limit first, then move one pixel along the (possibly new) direction.
  task automatic model_step(input int px, output bit m);
    m = 1'b0;
    if (mdx == 1 && mx == 159) mdx = 0;
    else if (mdx == 0 && mx == 0) mdx = 1;
    if (mdy == 0 && my == 0) mdy = 1;
    else if (mdy == 1 && my == 109 && px <= mx && mx <= px + 15) mdy = 0;
    else if (mdy == 1 && my == 119) m = 1'b1;
    if (m) begin
      model_reset();
    end else begin
      mx = (mdx == 1) ? mx + 1 : mx - 1;
      my = (mdy == 1) ? my + 1 : my - 1;
    end
  endtask

  task automatic check_ball(input string tag);
    chk({tag, "_ball_x"}, ball_x, mx);
    chk({tag, "_ball_y"}, ball_y, my);
    chk({tag, "_dir_x"}, dir_x, mdx);
    chk({tag, "_dir_y"}, dir_y, mdy);
  endtask

  // Entered at a negedge where plot_req must already be high; leaves one negedge after done.
  task automatic do_plot(input string tag, input int ex, input int ey, input int ecol, input int hold);
    chk({tag, "_req"}, plot_req, 1);
    chk({tag, "_x"}, plot_x, ex);
    chk({tag, "_y"}, plot_y, ey);
    chk({tag, "_colour"}, plot_colour, ecol);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk({tag, "_hold_req"}, plot_req, 1);
      chk({tag, "_hold_x"}, plot_x, ex);
    end
    plot_done = 1'b1;
    @(negedge clock);
    plot_done = 1'b0;
    chk({tag, "_req_drop"}, plot_req, 0);
  endtask

  task automatic serve(input int hold);
    go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    do_plot("serve", mx, my, 1, hold);
    check_ball("serve");
  endtask

  // Entered one negedge after the erase completed (DUT in MOVE).
  task automatic finish_step(input int px);
    bit m;
    model_step(px, m);
    @(negedge clock);
    if (m) begin
      chk("miss_pulse", miss, 1);
      chk("miss_req", plot_req, 0);
      check_ball("miss");
      @(negedge clock);
      chk("miss_clear", miss, 0);
      chk("miss_idle_req", plot_req, 0);
      serve($urandom_range(0, 2));
    end else begin
      chk("step_miss", miss, 0);
      do_plot("draw", mx, my, 1, $urandom_range(0, 3));
      check_ball("step");
    end
  endtask

  task automatic pick_paddle(output int px);
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0, 1, 2, 3, 4: px = mx - $urandom_range(0, 15);
      5:             px = mx + 1;
      6:             px = mx - 16;
      7:             px = mx - 15;
      8:             px = $urandom_range(240, 255);
      default:       px = $urandom_range(0, 255);
    endcase
    if (px < 0) px = 0;
    if (px > 255) px = 255;
  endtask

  task automatic do_step(input int px);
    paddle_x = px[7:0];
    tick = 1'b1;
    @(negedge clock);
    tick = 1'b0;
    do_plot("erase", mx, my, 0, $urandom_range(0, 3));
    finish_step(px);
  endtask

  initial begin
    int px;
    resetn    = 1'b0;
    tick      = 1'b0;
    go        = 1'b0;
    paddle_x  = '0;
    plot_done = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    chk("rst_req", plot_req, 0);
    chk("rst_plot_x", plot_x, 0);
    chk("rst_plot_y", plot_y, 0);
    chk("rst_colour", plot_colour, 0);
    chk("rst_miss", miss, 0);
    chk("rst_overrun", tick_overrun, 0);
    check_ball("rst");
    resetn = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("idle_no_req", plot_req, 0);
    end

    serve(2);
    repeat (5) begin
      @(negedge clock);
      chk("no_tick_no_req", plot_req, 0);
    end

    do_step(0);
    chk("first_step_x", ball_x, 81);
    chk("first_step_y", ball_y, 59);

    for (int s = 0; s < 900; s++) begin
      pick_paddle(px);
      do_step(px);
      if ($urandom_range(0, 3) == 0) begin
        plot_done = 1'b1;
        @(negedge clock);
        plot_done = 1'b0;
        chk("stray_done_req", plot_req, 0);
      end
    end
    chk("overrun_quiet", tick_overrun, 0);

    // Ticks while the erase is stalled are dropped, not queued.
    pick_paddle(px);
    paddle_x = px[7:0];
    tick = 1'b1;
    @(negedge clock);
    tick = 1'b0;
    chk("ovr_erase_req", plot_req, 1);
    chk("ovr_erase_x", plot_x, mx);
    for (int i = 0; i < 10; i++) begin
      tick = (i % 2 == 0);
      @(negedge clock);
      chk("ovr_hold_req", plot_req, 1);
    end
    tick = 1'b0;
    plot_done = 1'b1;
    @(negedge clock);
    plot_done = 1'b0;
    chk("ovr_req_drop", plot_req, 0);
    finish_step(px);
    chk("ovr_sticky", tick_overrun, 1);
    repeat (5) begin
      @(negedge clock);
      chk("ovr_no_queue", plot_req, 0);
    end

    // Asynchronous reset in the middle of an erase handshake.
    tick = 1'b1;
    @(negedge clock);
    tick = 1'b0;
    chk("mid_erase_req", plot_req, 1);
    #2 resetn = 1'b0;
    #1;
    model_reset();
    chk("async_req", plot_req, 0);
    chk("async_plot_x", plot_x, 0);
    chk("async_plot_y", plot_y, 0);
    chk("async_colour", plot_colour, 0);
    chk("async_miss", miss, 0);
    chk("async_overrun", tick_overrun, 0);
    check_ball("async");
    @(negedge clock);
    resetn = 1'b1;
    repeat (5) begin
      @(negedge clock);
      chk("post_rst_no_req", plot_req, 0);
    end
    serve(1);
    do_step(mx);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
